// File: rtl/free_list_pkg.sv
// free_list_pkg: shared rename-stage definitions for the physical-register
// free list. Provides the sys_defs macros (`BR_STATE_W, `BR_PR_WRONG,
// `PRF_IDX_W, `FL_DEPTH, `FL_PTR_W), typed localparam mirrors of them, and a
// popcount helper used to derive the free-entry count.
`ifndef FREE_LIST_SYS_DEFS
`define FREE_LIST_SYS_DEFS
`define BR_STATE_W    2
`define BR_PR_NONE    2'b00
`define BR_PR_CORRECT 2'b01
`define BR_PR_WRONG   2'b10
`define PRF_IDX_W     6
`define FL_DEPTH      32
`define FL_PTR_W      5
`endif

package free_list_pkg;

    localparam int FL_DEPTH   = `FL_DEPTH;
    localparam int FL_PTR_W   = `FL_PTR_W;
    localparam int PRF_IDX_W  = `PRF_IDX_W;
    localparam int BR_STATE_W = `BR_STATE_W;

    localparam logic [BR_STATE_W-1:0] BR_PR_NONE    = `BR_PR_NONE;
    localparam logic [BR_STATE_W-1:0] BR_PR_CORRECT = `BR_PR_CORRECT;
    localparam logic [BR_STATE_W-1:0] BR_PR_WRONG   = `BR_PR_WRONG;

    // Number of set bits in a valid vector (0..FL_DEPTH).
    function automatic logic [FL_PTR_W:0] popcount(input logic [FL_DEPTH-1:0] v);
        logic [FL_PTR_W:0] c;
        c = {(FL_PTR_W+1){1'b0}};
        for (int i = 0; i < FL_DEPTH; i++) begin
            c = c + {{FL_PTR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/fl_wrap_mask.sv
// fl_wrap_mask: combinational range decoder.
// Ports: start_ptr, end_ptr (pointers) -> mask, with mask[i]=1 for every slot
// i in the circular range [start_ptr, end_ptr). start_ptr==end_ptr gives an
// empty mask.
module fl_wrap_mask
    import free_list_pkg::*;
(
    input  logic [FL_PTR_W-1:0] start_ptr,
    input  logic [FL_PTR_W-1:0] end_ptr,
    output logic [FL_DEPTH-1:0] mask
);

    // Decode each slot against the (possibly wrapped) range.
    always_comb begin
        logic [FL_PTR_W-1:0] idx_s;
        mask  = {FL_DEPTH{1'b0}};
        idx_s = {FL_PTR_W{1'b0}};
        for (int i = 0; i < FL_DEPTH; i++) begin
            idx_s = FL_PTR_W'(i);
            if (start_ptr <= end_ptr) begin
                mask[i] = (idx_s >= start_ptr) && (idx_s < end_ptr);
            end else begin
                mask[i] = (idx_s >= start_ptr) || (idx_s < end_ptr);
            end
        end
    end

endmodule

// File: rtl/free_list_chk.sv
// free_list_chk: property checker for free_list.
// Ports: clk, rst (active-low), retire_en_i, tail_valid (valid bit of the
// slot a push would write). A push must never overwrite a slot still holding
// a free tag.
module free_list_chk (
    input logic clk,
    input logic rst,
    input logic retire_en_i,
    input logic tail_valid
);

    // Retire pushes only ever land in a released slot.
    push_into_free_slot_a : assert property (
        @(posedge clk) disable iff (!rst) retire_en_i |-> !tail_valid
    );

endmodule

// File: rtl/free_list.sv
// free_list: 32-entry circular free list of physical register tags for the
// rename stage. Dispatch pops the head tag, retire pushes freed tags at the
// tail, and a mispredict restores the head to a checkpointed value while
// re-validating every slot popped since that checkpoint.
// Ports:
//   clk, rst (async, active-low)
//   dispatch_en_i          pop request
//   free_tag_o, empty_o    head tag / no-tag-available
//   retire_en_i, retire_tag_i  push of a freed tag
//   bak_fl_head_o          head pointer for branch checkpoints
//   br_state_i, rc_fl_head_i   branch resolution and recovered head
//   free_cnt_o             number of free entries (0..32)
// Optional feature: FREE_LIST_BYPASS_EN lets a retiring tag satisfy a
// dispatch in the same cycle while the list is empty.
module free_list
    import free_list_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dispatch_en_i,
    output logic [PRF_IDX_W-1:0]  free_tag_o,
    output logic                  empty_o,
    input  logic                  retire_en_i,
    input  logic [PRF_IDX_W-1:0]  retire_tag_i,
    output logic [FL_PTR_W-1:0]   bak_fl_head_o,
    input  logic [BR_STATE_W-1:0] br_state_i,
    input  logic [FL_PTR_W-1:0]   rc_fl_head_i,
    output logic [FL_PTR_W:0]     free_cnt_o
);

    logic [PRF_IDX_W-1:0] tag_r [FL_DEPTH];
    logic [FL_DEPTH-1:0]  valid_r;
    logic [FL_DEPTH-1:0]  valid_nxt_s;
    logic [FL_DEPTH-1:0]  rec_mask_s;
    logic [FL_PTR_W-1:0]  head_r;
    logic [FL_PTR_W-1:0]  tail_r;
    logic [FL_PTR_W-1:0]  head_nxt_s;
    logic [FL_PTR_W-1:0]  tail_nxt_s;
    logic [FL_PTR_W:0]    free_cnt_r;
    logic                 recover_s;
    logic                 stored_empty_s;
    logic                 bypass_s;
    logic                 pop_s;

    assign recover_s      = (br_state_i == BR_PR_WRONG);
    assign stored_empty_s = (free_cnt_r == {(FL_PTR_W+1){1'b0}});

`ifdef FREE_LIST_BYPASS_EN
    assign bypass_s = stored_empty_s & retire_en_i;
`else
    assign bypass_s = 1'b0;
`endif

    // Slots popped since the checkpoint: [recovered head, current head).
    fl_wrap_mask u_rec_mask (
        .start_ptr (rc_fl_head_i),
        .end_ptr   (head_r),
        .mask      (rec_mask_s)
    );

    // Head tag, or the retiring tag forwarded straight through when bypassing.
    always_comb begin
        if (bypass_s) begin
            free_tag_o = retire_tag_i;
        end else begin
            free_tag_o = tag_r[head_r];
        end
    end

    assign empty_o       = stored_empty_s & ~bypass_s;
    assign bak_fl_head_o = head_r;
    assign free_cnt_o    = free_cnt_r;

    // A recovery cycle never carries a real dispatch, so the pop is dropped.
    assign pop_s = dispatch_en_i & ~empty_o & ~recover_s;

    // Next-state: recovery, then push, then pop. In a bypassed pop head==tail,
    // so the pop's clear overrides the push's set on the same slot.
    always_comb begin
        valid_nxt_s = valid_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        if (recover_s) begin
            valid_nxt_s = valid_nxt_s | rec_mask_s;
            head_nxt_s  = rc_fl_head_i;
        end else begin
            head_nxt_s  = head_r;
        end
        if (retire_en_i) begin
            valid_nxt_s[tail_r] = 1'b1;
            tail_nxt_s          = tail_r + FL_PTR_W'(1);
        end else begin
            tail_nxt_s          = tail_r;
        end
        if (pop_s) begin
            valid_nxt_s[head_r] = 1'b0;
            head_nxt_s          = head_r + FL_PTR_W'(1);
        end else begin
            valid_nxt_s[head_r] = valid_nxt_s[head_r];
        end
    end

    // Pointer, valid and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r    <= {FL_DEPTH{1'b1}};
            head_r     <= {FL_PTR_W{1'b0}};
            tail_r     <= {FL_PTR_W{1'b0}};
            free_cnt_r <= (FL_PTR_W+1)'(FL_DEPTH);
        end else begin
            valid_r    <= valid_nxt_s;
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            free_cnt_r <= popcount(valid_nxt_s);
        end
    end

    // Tag storage; reset hands out physical tags FL_DEPTH..2*FL_DEPTH-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                tag_r[i] <= PRF_IDX_W'(FL_DEPTH + i);
            end
        end else if (retire_en_i) begin
            tag_r[tail_r] <= retire_tag_i;
        end else begin
            tag_r[tail_r] <= tag_r[tail_r];
        end
    end

    free_list_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .retire_en_i (retire_en_i),
        .tail_valid  (valid_r[tail_r])
    );

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed scoreboard bench for free_list. Stimulus pushes the
// hand-computed outputs expected in each cycle; a negedge monitor pops and
// compares them against the DUT.
module tb_free_list;
    import free_list_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  dispatch_en_i = 1'b0;
    logic [PRF_IDX_W-1:0]  free_tag_o;
    logic                  empty_o;
    logic                  retire_en_i = 1'b0;
    logic [PRF_IDX_W-1:0]  retire_tag_i = '0;
    logic [FL_PTR_W-1:0]   bak_fl_head_o;
    logic [BR_STATE_W-1:0] br_state_i = BR_PR_NONE;
    logic [FL_PTR_W-1:0]   rc_fl_head_i = '0;
    logic [FL_PTR_W:0]     free_cnt_o;

    typedef struct {
        int         id;
        logic       chk_tag;
        logic [5:0] tag;
        logic       empty;
        logic [5:0] cnt;
        logic [4:0] head;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    free_list dut (
        .clk           (clk),
        .rst           (rst),
        .dispatch_en_i (dispatch_en_i),
        .free_tag_o    (free_tag_o),
        .empty_o       (empty_o),
        .retire_en_i   (retire_en_i),
        .retire_tag_i  (retire_tag_i),
        .bak_fl_head_o (bak_fl_head_o),
        .br_state_i    (br_state_i),
        .rc_fl_head_i  (rc_fl_head_i),
        .free_cnt_o    (free_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d got %0d want %0d", name, id, act, req);
        end
    endtask

    // Monitor: compare every queued expectation mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.chk_tag) cmp("free_tag", e.id, 32'(free_tag_o), 32'(e.tag));
            cmp("empty", e.id, 32'(empty_o), 32'(e.empty));
            cmp("free_cnt", e.id, 32'(free_cnt_o), 32'(e.cnt));
            cmp("head", e.id, 32'(bak_fl_head_o), 32'(e.head));
        end
    end

    task automatic expect_now(input logic ct, input logic [5:0] t, input logic em,
                              input logic [5:0] cnt, input logic [4:0] hd);
        exp_t e;
        e.id = step_id; e.chk_tag = ct; e.tag = t; e.empty = em; e.cnt = cnt; e.head = hd;
        step_id++;
        sb_q.push_back(e);
    endtask

    // One cycle: drive inputs after the edge, queue what must be visible now.
    task automatic cyc(input logic d, input logic r, input logic [5:0] rt,
                       input logic [1:0] br, input logic [4:0] rc,
                       input logic ct, input logic [5:0] t, input logic em,
                       input logic [5:0] cnt, input logic [4:0] hd);
        @(posedge clk); #1;
        dispatch_en_i = d; retire_en_i = r; retire_tag_i = rt;
        br_state_i = br; rc_fl_head_i = rc;
        expect_now(ct, t, em, cnt, hd);
    endtask

    task automatic pop(input logic [5:0] t, input logic [5:0] cnt, input logic [4:0] hd);
        cyc(1'b1, 1'b0, 6'd0, BR_PR_NONE, 5'd0, 1'b1, t, 1'b0, cnt, hd);
    endtask

    task automatic idle(input logic [5:0] t, input logic [5:0] cnt, input logic [4:0] hd);
        cyc(1'b0, 1'b0, 6'd0, BR_PR_NONE, 5'd0, 1'b1, t, 1'b0, cnt, hd);
    endtask

    task automatic idle_empty(input logic [4:0] hd);
        cyc(1'b0, 1'b0, 6'd0, BR_PR_NONE, 5'd0, 1'b0, 6'd0, 1'b1, 6'd0, hd);
    endtask

    // Asynchronous reset in mid-cycle; reset values must appear at once.
    task automatic mid_reset();
        @(posedge clk); #1;
        dispatch_en_i = 1'b0; retire_en_i = 1'b0; br_state_i = BR_PR_NONE;
        rst = 1'b0;
        expect_now(1'b1, 6'd32, 1'b0, 6'd32, 5'd0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int tg;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state, then drain all 32 tags in order.
        for (int i = 0; i < 32; i++) pop(6'(32 + i), 6'(32 - i), 5'(i));
        // 33rd pop against an empty list is ignored.
        cyc(1'b1, 1'b0, 6'd0, BR_PR_NONE, 5'd0, 1'b0, 6'd0, 1'b1, 6'd0, 5'd0);
        idle_empty(5'd0);

        // Empty list, retire tag 50 with a dispatch in the same cycle.
`ifdef FREE_LIST_BYPASS_EN
        cyc(1'b1, 1'b1, 6'd50, BR_PR_NONE, 5'd0, 1'b1, 6'd50, 1'b0, 6'd0, 5'd0);
`else
        cyc(1'b1, 1'b1, 6'd50, BR_PR_NONE, 5'd0, 1'b0, 6'd0, 1'b1, 6'd0, 5'd0);
        pop(6'd50, 6'd1, 5'd0);
`endif
        idle_empty(5'd1);

        // Wrap-around.
        mid_reset();
        for (int i = 0; i < 5; i++) pop(6'(32 + i), 6'(32 - i), 5'(i));
        cyc(1'b0, 1'b1, 6'd32, BR_PR_NONE, 5'd0, 1'b1, 6'd37, 1'b0, 6'd27, 5'd5);
        cyc(1'b0, 1'b1, 6'd33, BR_PR_NONE, 5'd0, 1'b1, 6'd37, 1'b0, 6'd28, 5'd5);
        for (int k = 0; k < 29; k++) begin
            tg = (k < 27) ? 37 + k : 32 + (k - 27);
            pop(6'(tg), 6'(29 - k), 5'((5 + k) % 32));
        end
        idle_empty(5'd2);

        // Recovery: checkpoint at head 3, four pops, mispredict.
        mid_reset();
        for (int i = 0; i < 3; i++) pop(6'(32 + i), 6'(32 - i), 5'(i));
        idle(6'd35, 6'd29, 5'd3);
        for (int i = 0; i < 4; i++) pop(6'(35 + i), 6'(29 - i), 5'(3 + i));
        cyc(1'b0, 1'b0, 6'd0, BR_PR_WRONG, 5'd3, 1'b1, 6'd39, 1'b0, 6'd25, 5'd7);
        idle(6'd35, 6'd29, 5'd3);

        // Recovery + push of tag 40 + dispatch in one cycle.
        pop(6'd35, 6'd29, 5'd3);
        pop(6'd36, 6'd28, 5'd4);
        cyc(1'b1, 1'b1, 6'd40, BR_PR_WRONG, 5'd3, 1'b1, 6'd37, 1'b0, 6'd27, 5'd5);
        idle(6'd35, 6'd30, 5'd3);

        // Recovery across the wrap point.
        cyc(1'b0, 1'b1, 6'd41, BR_PR_NONE, 5'd0, 1'b1, 6'd35, 1'b0, 6'd30, 5'd3);
        cyc(1'b0, 1'b1, 6'd42, BR_PR_NONE, 5'd0, 1'b1, 6'd35, 1'b0, 6'd31, 5'd3);
        for (int k = 0; k < 27; k++) pop(6'(35 + k), 6'(32 - k), 5'(3 + k));
        // Checkpoint cycle with a correct resolution, which must change nothing.
        cyc(1'b0, 1'b0, 6'd0, BR_PR_CORRECT, 5'd0, 1'b1, 6'd62, 1'b0, 6'd5, 5'd30);
        pop(6'd62, 6'd5, 5'd30);
        pop(6'd63, 6'd4, 5'd31);
        pop(6'd40, 6'd3, 5'd0);
        pop(6'd41, 6'd2, 5'd1);
        cyc(1'b0, 1'b0, 6'd0, BR_PR_WRONG, 5'd30, 1'b1, 6'd42, 1'b0, 6'd1, 5'd2);
        pop(6'd62, 6'd5, 5'd30);
        pop(6'd63, 6'd4, 5'd31);
        pop(6'd40, 6'd3, 5'd0);
        pop(6'd41, 6'd2, 5'd1);
        pop(6'd42, 6'd1, 5'd2);
        idle_empty(5'd3);

        @(posedge clk); #1;
        dispatch_en_i = 1'b0; retire_en_i = 1'b0; br_state_i = BR_PR_NONE;
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the R10K rename stage: a 32-entry circular FIFO of free physical tags (PRF of 64, architectural 32). Dispatch pops one tag per cycle, retire pushes the freed previous mapping. It is the free-list end of the branch-stack checkpoint interface. It exports its head pointer for snapshot at branch dispatch. On a mispredict it accepts the recovered head and re-frees every tag allocated after the branch.

## Interface
- FL_DEPTH, 32, entries (pointer width 5)
- PRF_IDX_W, 6, physical tag width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- dispatch_en_i  in  1  pop request: dispatching insn needs a destination tag
- free_tag_o  out  PRF_IDX_W  tag at head, valid when empty_o=0
- empty_o  out  1  no free tag; dispatch must stall
- retire_en_i  in  1  push request from ROB retire
- retire_tag_i  in  PRF_IDX_W  freed tag (retiring insn's old mapping)
- bak_fl_head_o  out  5  current head, snapshotted by branch stack at branch dispatch
- br_state_i  in  `BR_STATE_W  branch resolution state from ROB
- rc_fl_head_i  in  5  recovered head from branch stack, used when br_state_i==`BR_PR_WRONG
- free_cnt_o  out  6  number of valid entries, 0..32

## Operation
- Storage: tag[32], valid[32], head[4:0], tail[4:0]. Valid entries are the circular range [head, tail).
- Reset: tag[i]=32+i, valid all 1, head=0, tail=0. Outputs: free_tag_o=32, empty_o=0, free_cnt_o=32, bak_fl_head_o=0.
- Pop: when dispatch_en_i=1 and empty_o=0, clear valid[head] and set head=head+1 (mod 32). dispatch_en_i while empty is ignored.
- Push: when retire_en_i=1, write tag[tail]=retire_tag_i, set valid[tail]=1, tail=tail+1 (mod 32). Push into a valid slot is illegal and fires an assertion.
- Recovery: when br_state_i==`BR_PR_WRONG, set valid=1 for every slot in the circular range [rc_fl_head_i, head). If rc_fl_head_i==head the range is empty. Then head=rc_fl_head_i. Tags in those slots are untouched.
- Same-cycle events:
  - Recovery with dispatch_en_i: the pop is dropped; the branch stack guarantees no dispatch that cycle.
  - Recovery with push: both are applied. The push targets tail, which lies outside the recovered range.
  - Pop with push: both are applied.
  - Pop with push when empty: the pop is refused unless the bypass is enabled (see Configuration).
- Correct-branch resolution (any br_state_i other than WRONG): no effect.
- Constraint: fewer than 32 pops occur between a checkpoint and its recovery. The ROB depth guarantees this; the block does not check it.
- free_cnt_o = popcount(valid). empty_o = (free_cnt_o==0).

## Timing
- free_tag_o, empty_o, free_cnt_o and bak_fl_head_o are combinational from registers only. They carry no input-to-output paths, except in bypass mode.
- Pop, push and recovery take effect at the next rising edge. The new head tag is visible the cycle after.
- A checkpoint captured in cycle N holds the head before any pop in cycle N. A branch never pops.
- Recovery is a single-cycle restore; dispatch may resume the next cycle.
- Reset asserted mid-operation: the whole state returns to reset values immediately, including any recovery in progress.

## Configuration
- FREE_LIST_BYPASS_EN defined:
  - When empty_o would be 1 and retire_en_i=1, free_tag_o=retire_tag_i and empty_o=0 in the same cycle.
  - A pop in that cycle consumes the bypassed tag. The slot at tail is written and then immediately invalidated; head and tail both advance.
- Undefined: no combinational path from retire to dispatch; an empty list stalls at least one cycle.

## Structure
- Shared header (sys_defs): `BR_STATE_W, `BR_PR_WRONG, `PRF_IDX_W, `FL_DEPTH, `FL_PTR_W.
- Sub-module fl_wrap_mask: combinational.
  - Given start, end[4:0], outputs the 32-bit one-hot-range mask of slots in [start, end) with wrap-around.
  - Used for recovery re-validation; verified standalone.

## Test plan
- Reset then 32 pops -> free_tag_o sequence 32..63, then empty_o=1, free_cnt_o=0; a 33rd pop leaves head=0 unchanged.
- Wrap-around:
  - Stimulus: 5 pops, push tags 32,33, then 29 further pops.
  - Required: tags returned are 37..63 followed by 32, 33; empty_o=1.
- Recovery:
  - Stimulus: after 3 pops (head=3), snapshot bak_fl_head_o=3, 4 more pops (head=7), then WRONG with rc_fl_head_i=3.
  - Required: head=3, free_tag_o=35, free_cnt_o=29.
- Recovery across wrap:
  - Stimulus: head=30 at snapshot, 4 pops (head=2), WRONG with rc=30.
  - Required: slots 30, 31, 0, 1 valid again.
- Simultaneous events: WRONG + retire push of tag 40 + dispatch_en_i in one cycle -> recovery and push applied, pop dropped, free_cnt_o increases by recovered count + 1.
- Empty + retire of tag 50 with dispatch_en_i: with FREE_LIST_BYPASS_EN, free_tag_o=50 same cycle, count stays 0; without it, empty_o=1 and tag 50 appears next cycle.
